hsv_frame_ctrl: RTL and testbench

Frame-level sequencer placed between the camera pixel stream and the 6-stage streaming RGB-to-HSV pipeline. It arms on command and aligns capture to a frame boundary. It gates pixels into the pipeline only while a frame is active, flushes the pipeline after end-of-frame and reports per-frame pixel counts and error flags to the control/register block.

---
 rtl/hsv_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_hsv_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_frame_ctrl.sv
// Frame sequencer ahead of the RGB-to-HSV pipeline: arms on command, aligns to a frame edge, flushes and reports per frame.
// pipe_* lag in_* by 1 cycle; no backpressure, so pixels arriving during flush are dropped and flagged.
module hsv_frame_ctrl #(
  parameter int LATENCY = 6,
  parameter int CNT_W   = 20,
  parameter int FRM_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_stop,
  input  logic             ctrl_continuous,
  input  logic             ctrl_clear_err,
  input  logic             in_valid,
  input  logic             in_visual,
  input  logic             in_done,
  output logic             pipe_valid,
  output logic             pipe_visual,
  output logic             pipe_done,
  input  logic             pipe_out_valid,
  input  logic             pipe_out_visual,
  input  logic             pipe_out_done,
  output logic             busy,
  output logic             frame_ready,
  output logic [CNT_W-1:0] pixel_count,
  output logic [FRM_W-1:0] frame_count,
  output logic             err_dropped,
  output logic             err_timeout,
  output logic             err_mismatch
);

  typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, FLUSH, REPORT} state_t;

  localparam int               WD_W    = $clog2(LATENCY + 3);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, next_state;
  logic [WD_W-1:0]  wd;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             stop_pend;
  logic             timeout_exit;
  logic             enter_active, enter_flush;
  logic             in_pix, out_pix;
  logic             drop_evt, mismatch_evt;

  always_comb begin
    next_state   = state;
    timeout_exit = 1'b0;
    case (state)
      IDLE:   if (ctrl_start && !ctrl_stop) next_state = ARMED;
      ARMED:  if (ctrl_stop) next_state = IDLE;
              else if (in_done) next_state = ACTIVE;
      ACTIVE: if (in_done) next_state = FLUSH;
      FLUSH: begin
        if (pipe_out_done) begin
          next_state = REPORT;
        end else if (wd <= WD_W'(1)) begin
          // Watchdog about to expire: the pipeline never returned its done marker.
          next_state   = REPORT;
          timeout_exit = 1'b1;
        end
      end
      REPORT: next_state = (ctrl_continuous && !stop_pend && !ctrl_stop) ? ACTIVE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign enter_active = (state != ACTIVE) && (next_state == ACTIVE);
  assign enter_flush  = (state != FLUSH) && (next_state == FLUSH);
  assign in_pix       = in_valid && in_visual;
  assign out_pix      = pipe_out_valid && pipe_out_visual;
  assign drop_evt     = (state == FLUSH) && in_valid;
  assign mismatch_evt = (state == REPORT) && (in_cnt != out_cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      pipe_valid   <= 1'b0;
      pipe_visual  <= 1'b0;
      pipe_done    <= 1'b0;
      wd           <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      stop_pend    <= 1'b0;
      pixel_count  <= '0;
      frame_count  <= '0;
      err_dropped  <= 1'b0;
      err_timeout  <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      state       <= next_state;
      pipe_valid  <= (state == ACTIVE) && in_valid;
      pipe_visual <= (state == ACTIVE) && in_visual;
      pipe_done   <= (state == ACTIVE) && in_done;

      if (enter_flush)
        wd <= WD_LOAD;
      else if (state == FLUSH && wd != '0)
        wd <= wd - WD_W'(1);

      // Counters saturate rather than wrap so an oversize frame still reads as a mismatch-free maximum.
      if (enter_active) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (state == ACTIVE && in_pix && in_cnt != CNT_MAX)
          in_cnt <= in_cnt + CNT_W'(1);
        if ((state == ACTIVE || state == FLUSH) && out_pix && out_cnt != CNT_MAX)
          out_cnt <= out_cnt + CNT_W'(1);
      end

      if (state == REPORT)
        stop_pend <= 1'b0;
      else if (ctrl_stop && (state == ACTIVE || state == FLUSH))
        stop_pend <= 1'b1;

      if (state == REPORT) begin
        pixel_count <= in_cnt;
        frame_count <= frame_count + FRM_W'(1);
      end

      // A new error event in the same cycle as a clear keeps the flag set.
      err_dropped  <= drop_evt     || (err_dropped  && !ctrl_clear_err);
      err_timeout  <= timeout_exit || (err_timeout  && !ctrl_clear_err);
      err_mismatch <= mismatch_evt || (err_mismatch && !ctrl_clear_err);
    end
  end

  assign busy        = (state != IDLE);
  assign frame_ready = (state == REPORT);

endmodule

// File: tb/tb_hsv_frame_ctrl.sv
// Directed bench for hsv_frame_ctrl with a 6-deep pipeline model and report/pipe scoreboards.
module tb_hsv_frame_ctrl;
  localparam int LATENCY = 6;
  localparam int CNT_W   = 20;
  localparam int FRM_W   = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_start, ctrl_stop, ctrl_continuous, ctrl_clear_err;
  logic             in_valid, in_visual, in_done;
  logic             pipe_valid, pipe_visual, pipe_done;
  logic             pipe_out_valid, pipe_out_visual, pipe_out_done;
  logic             busy, frame_ready;
  logic [CNT_W-1:0] pixel_count;
  logic [FRM_W-1:0] frame_count;
  logic             err_dropped, err_timeout, err_mismatch;

  hsv_frame_ctrl #(.LATENCY(LATENCY), .CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
    .clock(clock), .reset(reset),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .ctrl_continuous(ctrl_continuous), .ctrl_clear_err(ctrl_clear_err),
    .in_valid(in_valid), .in_visual(in_visual), .in_done(in_done),
    .pipe_valid(pipe_valid), .pipe_visual(pipe_visual), .pipe_done(pipe_done),
    .pipe_out_valid(pipe_out_valid), .pipe_out_visual(pipe_out_visual),
    .pipe_out_done(pipe_out_done),
    .busy(busy), .frame_ready(frame_ready),
    .pixel_count(pixel_count), .frame_count(frame_count),
    .err_dropped(err_dropped), .err_timeout(err_timeout), .err_mismatch(err_mismatch)
  );

  always #5 clock = ~clock;

  // Pipeline model: pure delay line, with optional done suppression and single-pixel drop.
  logic [LATENCY-1:0] sv = '0, svis = '0, sdn = '0;
  int  drop_req = 0;
  int  drop_done = 0;
  bit  suppress_done = 1'b0;

  always @(posedge clock) begin
    logic drop_now;
    drop_now = pipe_valid && pipe_visual && (drop_req != drop_done);
    if (drop_now) drop_done <= drop_done + 1;
    sv   <= {sv[LATENCY-2:0],   pipe_valid && !drop_now};
    svis <= {svis[LATENCY-2:0], pipe_visual};
    sdn  <= {sdn[LATENCY-2:0],  pipe_done};
  end

  assign pipe_out_valid  = sv[LATENCY-1];
  assign pipe_out_visual = svis[LATENCY-1];
  assign pipe_out_done   = sdn[LATENCY-1] && !suppress_done;

  typedef struct packed { logic v; logic vis; logic dn; } pipe_t;
  typedef struct { int dcyc; int lat; int pix; bit to; bit mm; bit dr; } rep_t;

  pipe_t pipe_q[$];
  rep_t  rep_q[$];
  rep_t  cur;
  bit    pend = 1'b0;
  int    cyc = 0;
  int    exp_frm = 0;
  int    nvec = 0;
  int    nerr = 0;
  int    g_lat = LATENCY + 2;
  bit    g_to = 1'b0, g_mm = 1'b0, g_dr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    pipe_t pe;
    @(posedge clock);
    #1;
    cyc++;
    if (pipe_q.size() > 0) begin
      pe = pipe_q.pop_front();
      check("pipe_valid",  {31'd0, pipe_valid},  {31'd0, pe.v});
      check("pipe_visual", {31'd0, pipe_visual}, {31'd0, pe.vis});
      check("pipe_done",   {31'd0, pipe_done},   {31'd0, pe.dn});
    end
    if (pend) begin
      pend = 1'b0;
      check("pixel_count",  32'(pixel_count),    32'(cur.pix));
      check("frame_count",  32'(frame_count),    32'(exp_frm));
      check("err_dropped",  {31'd0, err_dropped},  {31'd0, cur.dr});
      check("err_timeout",  {31'd0, err_timeout},  {31'd0, cur.to});
      check("err_mismatch", {31'd0, err_mismatch}, {31'd0, cur.mm});
    end
    if (frame_ready) begin
      if (rep_q.size() == 0) begin
        check("spurious_frame_ready", {31'd0, frame_ready}, 32'd0);
      end else begin
        cur     = rep_q.pop_front();
        exp_frm = (exp_frm + 1) % 65536;
        check("frame_ready_latency", 32'(cyc - cur.dcyc), 32'(cur.lat));
        check("timeout_at_ready", {31'd0, err_timeout}, {31'd0, cur.to});
        pend = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic v, input logic vis, input logic dn, input logic gate);
    pipe_t pe;
    in_valid  = v;
    in_visual = vis;
    in_done   = dn;
    pe.v   = v & gate;
    pe.vis = vis & gate;
    pe.dn  = dn & gate;
    pipe_q.push_back(pe);
    tick();
    ctrl_start     = 1'b0;
    ctrl_stop      = 1'b0;
    ctrl_clear_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // nvis visual pixels (last one optionally on the done cycle), nnon non-visual, then in_done.
  task automatic frame(input int nvis, input int nnon, input bit last_with_done, input int stop_at);
    rep_t r;
    for (int i = 0; i < nvis - (last_with_done ? 1 : 0); i++) begin
      if (i == stop_at) ctrl_stop = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < nnon; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
    r.dcyc = cyc; r.lat = g_lat; r.pix = nvis; r.to = g_to; r.mm = g_mm; r.dr = g_dr;
    rep_q.push_back(r);
    drive(last_with_done, last_with_done, 1'b1, 1'b1);
  endtask

  task automatic arm_and_align();
    ctrl_start = 1'b1;
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_continuous = 1'b0; ctrl_clear_err = 1'b0;
    in_valid = 1'b0; in_visual = 1'b0; in_done = 1'b0;
    idle(2);
    check("rst_busy",        {31'd0, busy},         32'd0);
    check("rst_frame_ready", {31'd0, frame_ready},  32'd0);
    check("rst_pixel_count", 32'(pixel_count),      32'd0);
    check("rst_frame_count", 32'(frame_count),      32'd0);
    check("rst_errors",      {29'd0, err_dropped, err_timeout, err_mismatch}, 32'd0);
    reset = 1'b0;
    idle(1);

    // start and stop together: stop wins
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    idle(1);
    check("start_stop_same", {31'd0, busy}, 32'd0);
    // stop while armed
    ctrl_start = 1'b1;
    idle(1);
    check("armed_busy", {31'd0, busy}, 32'd1);
    ctrl_stop = 1'b1;
    idle(1);
    check("armed_stop", {31'd0, busy}, 32'd0);

    // single frame
    arm_and_align();
    frame(12, 4, 1'b0, -1);
    idle(12);
    check("single_busy_after", {31'd0, busy}, 32'd0);

    // alignment: pixels before first in_done are discarded
    ctrl_start = 1'b1;
    idle(1);
    repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    frame(7, 0, 1'b0, -1);
    idle(12);

    // continuous: three frames, stop during the third
    ctrl_continuous = 1'b1;
    arm_and_align();
    frame(10, 0, 1'b0, -1);
    idle(12);
    check("cont_busy_between", {31'd0, busy}, 32'd1);
    frame(20, 0, 1'b0, -1);
    idle(12);
    frame(30, 0, 1'b1, 15);
    idle(12);
    check("cont_busy_after_stop", {31'd0, busy}, 32'd0);
    ctrl_continuous = 1'b0;

    // blanking violation
    g_dr = 1'b1;
    arm_and_align();
    frame(5, 0, 1'b0, -1);
    idle(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("dropped_set", {31'd0, err_dropped}, 32'd1);
    idle(11);
    ctrl_clear_err = 1'b1;
    idle(1);
    check("dropped_cleared", {31'd0, err_dropped}, 32'd0);
    g_dr = 1'b0;

    // timeout and mismatch
    suppress_done = 1'b1;
    drop_req++;
    g_lat = LATENCY + 3; g_to = 1'b1; g_mm = 1'b1;
    arm_and_align();
    frame(8, 0, 1'b0, -1);
    idle(12);
    suppress_done = 1'b0;
    ctrl_clear_err = 1'b1;
    idle(1);
    check("timeout_cleared",  {31'd0, err_timeout},  32'd0);
    check("mismatch_cleared", {31'd0, err_mismatch}, 32'd0);
    g_lat = LATENCY + 2; g_to = 1'b0; g_mm = 1'b0;

    // reset mid-frame
    arm_and_align();
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    idle(1);
    exp_frm = 0;
    check("midrst_busy",        {31'd0, busy},        32'd0);
    check("midrst_frame_count", 32'(frame_count),     32'd0);
    check("midrst_pixel_count", 32'(pixel_count),     32'd0);
    check("midrst_outputs", {26'd0, frame_ready, pipe_valid, pipe_visual, pipe_done, err_dropped, err_timeout | err_mismatch}, 32'd0);
    reset = 1'b0;
    idle(14);

    check("reports_outstanding", 32'(rep_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
